// File: rtl/bram_scroll_reader.sv
// Read side of the dual-port display BRAM: walks a NUM_COLS-wide scroll window
// through port B and hands each column word to the display driver via valid/ready.
module bram_scroll_reader #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 16,
  parameter int NUM_COLS   = 8,
  parameter int SCROLL_DIV = 4,
  localparam int CW = (NUM_COLS   > 1) ? $clog2(NUM_COLS)   : 1,
  localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  output logic [ADDR_W-1:0] addrb,
  output logic              enb,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] col_data,
  output logic [CW-1:0]     col_idx,
  output logic              col_valid,
  input  logic              col_ready,
  output logic              frame_done,
  output logic [ADDR_W-1:0] offset
);

  localparam logic [CW-1:0] LAST_COL   = CW'(NUM_COLS - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [FW-1:0]     frame_cnt;
  logic [ADDR_W-1:0] next_offset;

  // Offset the next frame starts from; lets a back-to-back frame use the stepped value.
  always_comb begin
    next_offset = offset;
    if (frame_cnt == LAST_FRAME)
      next_offset = offset + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addrb      <= '0;
      enb        <= 1'b0;
      col_data   <= '0;
      col_idx    <= '0;
      col_valid  <= 1'b0;
      frame_done <= 1'b0;
      offset     <= '0;
      frame_cnt  <= '0;
      col        <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            col   <= '0;
            enb   <= 1'b1;
            addrb <= offset;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          enb   <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          col_data  <= data_out;
          col_idx   <= col;
          col_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (col_ready) begin
            col_valid <= 1'b0;
            if (col != LAST_COL) begin
              col   <= col + CW'(1);
              addrb <= offset + ADDR_W'(col) + ADDR_W'(1);
              enb   <= 1'b1;
              state <= ISSUE;
            end else begin
              // Frame boundary: count the frame, step the scroll, and only now look at run.
              frame_done <= 1'b1;
              col        <= '0;
              offset     <= next_offset;
              frame_cnt  <= (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + FW'(1);
              if (run) begin
                enb   <= 1'b1;
                addrb <= next_offset;
                state <= ISSUE;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_scroll_reader.sv
// Directed bench for bram_scroll_reader with a 1-cycle-latency BRAM model holding 16'h1000+addr.
module tb_bram_scroll_reader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int NUM_COLS = 4;
  localparam int SCROLL_DIV = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              run;
  logic [ADDR_W-1:0] addrb;
  logic              enb;
  logic [DATA_W-1:0] data_out = '0;
  logic [DATA_W-1:0] col_data;
  logic [1:0]        col_idx;
  logic              col_valid;
  logic              col_ready;
  logic              frame_done;
  logic [ADDR_W-1:0] offset;

  int assertCount = 0;
  int failCount = 0;
  logic [3:0] expOff = 4'd0;
  int expFrames = 0;

  bram_scroll_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_COLS(NUM_COLS), .SCROLL_DIV(SCROLL_DIV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .addrb(addrb), .enb(enb),
    .data_out(data_out), .col_data(col_data), .col_idx(col_idx),
    .col_valid(col_valid), .col_ready(col_ready), .frame_done(frame_done),
    .offset(offset)
  );

  always #5 clk = ~clk;

  // BRAM port B model: registered read, contents mem[i] = 16'h1000 + i
  always @(posedge clk)
    if (enb) data_out <= 16'h1000 + {12'h000, addrb};

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic waitValid(output bit ok);
    int n;
    n = 0;
    while (!col_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = col_valid;
    if (!ok) checkOutput("valid_timeout", 32'(col_valid), 32'd1);
  endtask

  // Runs one frame at expected offset expOff; optional stall and run drop on a column
  task automatic applyStimulus(input int stallCol, input int dropCol);
    bit ok;
    logic [3:0] a;
    for (int c = 0; c < NUM_COLS; c++) begin
      waitValid(ok);
      if (!ok) return;
      a = expOff + 4'(c);
      checkOutput("col_idx", 32'(col_idx), 32'(c));
      checkOutput("col_data", 32'(col_data), 32'(16'h1000 + {12'h000, a}));
      checkOutput("offset", 32'(offset), 32'(expOff));
      if (c == stallCol) begin
        col_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checkOutput("stall_valid", 32'(col_valid), 32'd1);
          checkOutput("stall_data", 32'(col_data), 32'(16'h1000 + {12'h000, a}));
          checkOutput("stall_enb", 32'(enb), 32'd0);
        end
        col_ready = 1'b1;
      end
      if (c == dropCol) run = 1'b0;
      @(negedge clk);
      checkOutput("frame_done", 32'(frame_done), (c == NUM_COLS - 1) ? 32'd1 : 32'd0);
    end
    expFrames++;
    if (expFrames == SCROLL_DIV) begin
      expFrames = 0;
      expOff = expOff + 4'd1;
    end
    checkOutput("offset_after", 32'(offset), 32'(expOff));
  endtask

  initial begin
    bit ok;
    reset_n = 1'b0;
    run = 1'b0;
    col_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 32'(col_valid), 32'd0);
    checkOutput("rst_enb", 32'(enb), 32'd0);
    checkOutput("rst_offset", 32'(offset), 32'd0);
    checkOutput("rst_idx", 32'(col_idx), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_enb", 32'(enb), 32'd0);

    // Latency: enb one cycle after run, col_valid three cycles after
    run = 1'b1;
    @(negedge clk);
    checkOutput("lat_enb", 32'(enb), 32'd1);
    checkOutput("lat_addr", 32'(addrb), 32'd0);
    @(negedge clk);
    checkOutput("lat_enb_off", 32'(enb), 32'd0);
    checkOutput("lat_valid2", 32'(col_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat_valid3", 32'(col_valid), 32'd1);

    repeat (4) applyStimulus(-1, -1);
    checkOutput("offset_4frames", 32'(offset), 32'd2);

    while (expOff != 4'd14 && failCount == 0) applyStimulus(-1, -1);
    repeat (4) applyStimulus(-1, -1);
    checkOutput("offset_wrapped", 32'(offset), 32'd0);

    applyStimulus(1, -1);
    applyStimulus(-1, 1);
    checkOutput("drop_enb", 32'(enb), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("idle_enb2", 32'(enb), 32'd0);
    checkOutput("idle_valid", 32'(col_valid), 32'd0);
    checkOutput("idle_offset", 32'(offset), 32'd1);

    // Reset while holding a column
    col_ready = 1'b0;
    run = 1'b1;
    @(negedge clk);
    waitValid(ok);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("mrst_valid", 32'(col_valid), 32'd0);
    checkOutput("mrst_enb", 32'(enb), 32'd0);
    checkOutput("mrst_offset", 32'(offset), 32'd0);
    checkOutput("mrst_idx", 32'(col_idx), 32'd0);
    expOff = 4'd0;
    expFrames = 0;
    @(negedge clk);
    col_ready = 1'b1;
    reset_n = 1'b1;
    applyStimulus(-1, -1);
    checkOutput("mrst_offset1", 32'(offset), 32'd0);
    applyStimulus(-1, -1);
    checkOutput("mrst_offset2", 32'(offset), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/bram_scroll_reader.md
Name: bram_scroll_reader

Overview:
- Read-side consumer of the dual-port display BRAM.
- Walks BRAM port B through a window of NUM_COLS consecutive addresses starting at a scroll offset, with 1-cycle read latency.
- Presents each column word to the display driver over a valid/ready handshake.
- Advances the scroll offset by one address every SCROLL_DIV completed frames, producing the scrolling effect for content that port A has written.

Parameters:
ADDR_W, 4, BRAM address width; the scroll window wraps modulo 2^ADDR_W
DATA_W, 16, BRAM word / column data width
NUM_COLS, 8, columns per frame (1..2^ADDR_W)
SCROLL_DIV, 4, frames per offset step (>=1)

Ports:
clk  in  1  single clock; also drives BRAM port B
reset_n  in  1  asynchronous active-low reset
run  in  1  enable; sampled only in IDLE and at frame end
addrb  out  ADDR_W  BRAM port B address
enb  out  1  BRAM port B enable
data_out  in  DATA_W  BRAM port B read data, valid 1 cycle after enb
col_data  out  DATA_W  current column word
col_idx  out  clog2(NUM_COLS)  column index within frame
col_valid  out  1  col_data/col_idx valid
col_ready  in  1  display driver accepts the column
frame_done  out  1  1-cycle pulse on acceptance of the last column
offset  out  ADDR_W  current scroll offset

Behaviour:
- Reset (async assert, sync release): state=IDLE. addrb, enb, col_data, col_idx, col_valid, frame_done, offset, frame counter, column counter all 0.
- FSM states: IDLE, ISSUE, CAPTURE, HOLD.
- IDLE: if run=1, go to ISSUE next cycle with column counter=0.
- ISSUE (exactly 1 cycle): enb=1, addrb=(offset+col) mod 2^ADDR_W. Go to CAPTURE.
- CAPTURE (1 cycle): enb=0. Register col_data<=data_out and col_idx<=col. Set col_valid=1 from the next cycle. Go to HOLD.
- HOLD: col_valid=1. col_data and col_idx are held stable until the cycle col_ready=1 (handshake cycle).
- Handshake cycle: col_valid clears on the next edge. col_valid may not drop without a handshake.
- If handshake and col<NUM_COLS-1: col++, go to ISSUE.
- If handshake and col=NUM_COLS-1:
  - frame_done=1 in the cycle after the handshake (registered pulse, 1 cycle).
  - Frame counter increments. On reaching SCROLL_DIV it clears to 0 and offset<=offset+1 (mod 2^ADDR_W, 15->0 at default). The new offset takes effect for the next frame only.
  - Then go to ISSUE if run=1, else IDLE.
- col_ready asserted while col_valid=0 is ignored.
- Latency: run high in IDLE -> enb at cycle +1 -> col_valid at cycle +3. With col_ready tied high, throughput is 1 column per 3 cycles.
- run deasserted mid-frame: the current frame completes fully, including frame_done and offset update; the FSM then returns to IDLE.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded and does not count toward SCROLL_DIV.
- Window crossing the top address wraps: offset=14, NUM_COLS=4 reads 14,15,0,1.
- enb is never asserted outside ISSUE. The block never writes the BRAM.

Test Plan:
- Test BRAM model: mem[i]=16'h1000+i. Bench parameters NUM_COLS=4, SCROLL_DIV=2, col_ready=1.
- Basic frame: release reset, run=1 -> col_data 1000,1001,1002,1003 with col_idx 0..3. frame_done pulses once after col_idx=3 is accepted. First col_valid appears 3 cycles after run.
- Scroll step: run 4 frames -> offset 0,0,1,1 per frame. Frame 3 data is 1001,1002,1003,1004. offset=2 after frame 4.
- Wrap: run until offset=14 -> frame reads 100E,100F,1000,1001. After 2 frames at offset=15, offset becomes 0.
- Backpressure: hold col_ready=0 for 5 cycles on col_idx=1 -> col_valid stays 1, col_data stays 1001, enb stays 0. One cycle of col_ready=1 -> next column 1002 follows.
- Run drop: deassert run during col_idx=1 -> col_idx 2 and 3 are still delivered, frame_done pulses, FSM idles with enb=0.
- Reset mid-frame: assert reset_n=0 during HOLD -> col_valid, enb, offset and counters are 0 immediately. After release with run=1, the frame restarts at col_idx=0, data 1000.
